// File: rtl/fp_pkg.sv
// Shared FPU definitions: divider FSM states, format derivation helpers and
// canonical special-value constants for single and double precision.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_FINISH
  } fp_div_state_t;

  function automatic int fp_fw(input int w);
    return (w == 64) ? 52 : 23;
  endfunction

  function automatic int fp_ew(input int w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int fp_bias(input int w);
    return (1 << (fp_ew(w) - 1)) - 1;
  endfunction

  localparam logic [31:0] FP_QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] FP_QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] FP_INF32  = 32'h7F80_0000;
  localparam logic [63:0] FP_INF64  = 64'h7FF0_0000_0000_0000;

endpackage

// File: rtl/fp_div_round.sv
// Combinational normalize, round-to-nearest (ties away) and overflow/underflow
// clamp of the raw divider quotient into a packed IEEE-754 result.
module fp_div_round
  import fp_pkg::*;
#(
  parameter int W = 32,
  localparam int FW = fp_fw(W),
  localparam int EW = fp_ew(W)
)
(
  input  logic [FW+3:0]        i_q,
  input  logic signed [EW+1:0] i_exp,
  input  logic                 i_sign,
  output logic [W-1:0]         o_y
);

  localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
  localparam logic signed [EW+1:0] EXP_ZERO = '0;

  logic [FW:0]          w_sig;
  logic [FW:0]          w_sig_r;
  logic                 w_guard;
  logic [FW+1:0]        w_sum;
  logic signed [EW+1:0] w_exp_n;
  logic signed [EW+1:0] w_exp_r;
  logic                 w_unused;

  // Q lies in [2^(FW+2), 2^(FW+4)), so at most one left shift normalizes it
  always_comb begin
    w_sig   = i_q[FW+3:3];
    w_guard = i_q[2];
    w_exp_n = i_exp;
    if (!i_q[FW+3]) begin
      w_sig   = i_q[FW+2:2];
      w_guard = i_q[1];
      w_exp_n = i_exp - EXP_ONE;
    end

    w_sum   = {1'b0, w_sig} + {{(FW+1){1'b0}}, w_guard};
    w_sig_r = w_sum[FW:0];
    w_exp_r = w_exp_n;
    if (w_sum[FW+1]) begin
      w_sig_r = w_sum[FW+1:1];
      w_exp_r = w_exp_n + EXP_ONE;
    end

    o_y = {i_sign, w_exp_r[EW-1:0], w_sig_r[FW-1:0]};
    if (w_exp_r >= EXP_MAX) begin
      o_y = {i_sign, {EW{1'b1}}, {FW{1'b0}}};
    end else if (w_exp_r <= EXP_ZERO) begin
      o_y = {i_sign, {(W-1){1'b0}}};
    end
  end

  assign w_unused = ^{i_q[0], w_sig_r[FW]};

endmodule

// File: rtl/fp_div.sv
// Iterative restoring radix-2 FP divider, start/ready handshake, FW+6 cycle latency;
// FP_DIV_EARLY_OUT_EN lets special operands skip DIVIDE (result 2 cycles after accept).
module fp_div
  import fp_pkg::*;
#(
  parameter int W = 32
)
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         y_valid,
  output logic [W-1:0] y
);

  localparam int FW   = fp_fw(W);
  localparam int EW   = fp_ew(W);
  localparam int BIAS = fp_bias(W);
  localparam logic [5:0]  CNT_INIT = 6'(FW + 3);
  localparam logic [63:0] QNAN_ALL = (W == 64) ? FP_QNAN64 : {32'h0, FP_QNAN32};
  localparam logic [63:0] INF_ALL  = (W == 64) ? FP_INF64  : {32'h0, FP_INF32};
  localparam logic [W-1:0] QNAN    = QNAN_ALL[W-1:0];
  localparam logic [W-1:0] INF     = INF_ALL[W-1:0];

  fp_div_state_t        r_state, w_state_nxt;
  logic [5:0]           r_cnt;
  logic [FW+2:0]        r_rem;
  logic [FW:0]          r_mb;
  logic [FW+3:0]        r_q;
  logic signed [EW+1:0] r_exp;
  logic                 r_sign, r_special, r_y_valid;
  logic [W-1:0]         r_spec_res, r_y;

  logic [EW-1:0]        w_ea, w_eb;
  logic [FW-1:0]        w_fa, w_fb;
  logic                 w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic                 w_sign, w_nan, w_inf, w_zero, w_special, w_accept, w_ge;
  logic [W-1:0]         w_spec_res, w_round_y;
  logic signed [EW+1:0] w_exp_in;
  logic [FW+2:0]        w_diff;
  logic                 w_unused;

  assign w_ea     = a[W-2:FW];
  assign w_eb     = b[W-2:FW];
  assign w_fa     = a[FW-1:0];
  assign w_fb     = b[FW-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);
  assign w_sign   = a[W-1] ^ b[W-1];

  // Priority: NaN-producing cases, then infinity, then zero
  assign w_nan     = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_inf     = w_a_inf | w_b_zero;
  assign w_zero    = w_a_zero | w_b_inf;
  assign w_special = w_nan | w_inf | w_zero;

  always_comb begin
    w_spec_res = {w_sign, {(W-1){1'b0}}};
    if (w_nan)      w_spec_res = QNAN;
    else if (w_inf) w_spec_res = {w_sign, INF[W-2:0]};
  end

  assign w_exp_in = {2'b00, w_ea} - {2'b00, w_eb} + (EW+2)'(BIAS);
  assign w_accept = start && (r_state == ST_IDLE);
  assign w_ge     = (r_rem >= {2'b00, r_mb});
  assign w_diff   = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
  assign w_unused = w_diff[FW+2];

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
`ifdef FP_DIV_EARLY_OUT_EN
        if (start) w_state_nxt = w_special ? ST_FINISH : ST_DIVIDE;
`else
        if (start) w_state_nxt = ST_DIVIDE;
`endif
      end
      ST_DIVIDE: if (r_cnt == '0) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_mb       <= '0;
      r_q        <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_y_valid <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_cnt      <= CNT_INIT;
        r_rem      <= {2'b01, w_fa};
        r_mb       <= {1'b1, w_fb};
        r_q        <= '0;
        r_exp      <= w_exp_in;
        r_sign     <= w_sign;
        r_special  <= w_special;
        r_spec_res <= w_spec_res;
      end else if (r_state == ST_DIVIDE) begin
        r_rem <= {w_diff[FW+1:0], 1'b0};
        r_q   <= {r_q[FW+2:0], w_ge};
        if (r_cnt != '0) r_cnt <= r_cnt - 6'd1;
      end
      if (r_state == ST_FINISH) r_y <= r_special ? r_spec_res : w_round_y;
    end
  end

  fp_div_round #(.W(W)) u_round (
    .i_q    (r_q),
    .i_exp  (r_exp),
    .i_sign (r_sign),
    .o_y    (w_round_y)
  );

  assign y_valid = r_y_valid;
  assign y       = r_y;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div (W=32): expected results queued at issue, checked on y_valid.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        ready, y_valid;
  logic [31:0] y;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb_q[$];

  localparam int LAT = 29;
`ifdef FP_DIV_EARLY_OUT_EN
  localparam int LAT_SPEC = 2;
`else
  localparam int LAT_SPEC = 29;
`endif

  fp_div #(.W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .y_valid (y_valid),
    .y       (y)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of cycle 1 with operands scrambled.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ey);
    sb_q.push_back(ey);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_valid(input int lat_in, output int lat);
    lat = lat_in;
    while (y_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (y_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_total++; if (ready !== 1'b1) $display("FAIL reset ready: got %b want 1", ready); else n_pass++;
    n_total++; if (y_valid !== 1'b0) $display("FAIL reset y_valid: got %b want 0", y_valid); else n_pass++;
    n_total++; if (y !== 32'h0) $display("FAIL reset y: got %h want 00000000", y); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal;
    logic [31:0] va[5] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb[5] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3E800000, 32'h7F000000};
    logic [31:0] ve[5] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0800000, 32'h7F800000, 32'h00000000};
    logic [31:0] ey;
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], ve[i]);
      wait_valid(1, lat);
      ey = sb_q.pop_front();
      n_total++; if (y !== ey) $display("FAIL normal[%0d] y: got %h want %h", i, y, ey); else n_pass++;
      n_total++; if (lat !== LAT) $display("FAIL normal[%0d] latency: got %0d want %0d", i, lat, LAT); else n_pass++;
      n_total++; if (ready !== 1'b1) $display("FAIL normal[%0d] ready at y_valid: got %b want 1", i, ready); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_specials;
    logic [31:0] va[9] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000, 32'h80000000,
                           32'h7F800000, 32'h7F800001, 32'h40A00000, 32'hFF800000};
    logic [31:0] vb[9] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h40A00000, 32'h40A00000,
                           32'hFF800000, 32'h3F800000, 32'h7F800000, 32'h40000000};
    logic [31:0] ve[9] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h80000000,
                           32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'hFF800000};
    logic [31:0] ey;
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue(va[i], vb[i], ve[i]);
      wait_valid(1, lat);
      ey = sb_q.pop_front();
      n_total++; if (y !== ey) $display("FAIL special[%0d] y: got %h want %h", i, y, ey); else n_pass++;
      n_total++; if (lat !== LAT_SPEC) $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, LAT_SPEC); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] ey;
    int lat, extra;
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (4) @(negedge clk);
    n_total++; if (ready !== 1'b0) $display("FAIL ignore ready mid-divide: got %b want 0", ready); else n_pass++;
    a = 32'h41100000; b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(6, lat);
    ey = sb_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL ignore y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL ignore latency: got %0d want %0d", lat, LAT); else n_pass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid === 1'b1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL ignore extra pulses: got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ey;
    int lat;
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    wait_valid(1, lat);
    ey = sb_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL b2b first y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL b2b ready at y_valid: got %b want 1", ready); else n_pass++;
    issue(32'hC1000000, 32'h40000000, 32'hC0800000);
    wait_valid(1, lat);
    ey = sb_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL b2b second y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL b2b second latency: got %0d want %0d", lat, LAT); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [31:0] ey;
    int lat, extra;
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    n_total++; if (ready !== 1'b1) $display("FAIL abort ready: got %b want 1", ready); else n_pass++;
    n_total++; if (y !== 32'h0) $display("FAIL abort y: got %h want 00000000", y); else n_pass++;
    n_total++; if (y_valid !== 1'b0) $display("FAIL abort y_valid: got %b want 0", y_valid); else n_pass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid === 1'b1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL abort stale pulses: got %0d want 0", extra); else n_pass++;
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000);
    wait_valid(1, lat);
    ey = sb_q.pop_front();
    n_total++; if (y !== ey) $display("FAIL abort fresh y: got %h want %h", y, ey); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL abort fresh latency: got %0d want %0d", lat, LAT); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset;
    test_normal;
    test_specials;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
